// File: rtl/block_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : block_serial_subtractor
// Brief    : Multi-cycle subtractor, one BLOCK-bit slice per clock, LSB first,
//            with equal-operand borrow bypass. Macro SUB_FLAGS_EN adds zero/neg/ovf.
// Revision : 1.0 - initial release
// ============================================================================
module block_serial_subtractor #(
  parameter int WIDTH = 32,
  parameter int BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
`ifdef SUB_FLAGS_EN
  output logic             zero,
  output logic             neg,
  output logic             ovf,
`endif
  output logic             b_out
);

  localparam int NBLK = WIDTH / BLOCK;
  localparam int KW   = (NBLK > 1) ? $clog2(NBLK) : 1;

  localparam logic [KW-1:0] c_last = KW'(NBLK - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [KW-1:0]    r_k;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_borrow;
  logic [WIDTH-1:0] r_diff;
  logic             r_b_out;

  logic [BLOCK-1:0] w_a_slc;
  logic [BLOCK-1:0] w_b_slc;
  logic [BLOCK:0]   w_sub;
  logic             w_bo;
  logic [WIDTH-1:0] w_diff_nxt;

  assign w_a_slc = r_a[r_k*BLOCK +: BLOCK];
  assign w_b_slc = r_b[r_k*BLOCK +: BLOCK];
  assign w_sub   = {1'b0, w_a_slc} - {1'b0, w_b_slc} - {{BLOCK{1'b0}}, r_borrow};

  // Equal slices produce a - b = 0, so the outgoing borrow is the incoming one.
  assign w_bo = (w_a_slc == w_b_slc) ? r_borrow : w_sub[BLOCK];

  always_comb begin
    w_diff_nxt = r_diff;
    w_diff_nxt[r_k*BLOCK +: BLOCK] = w_sub[BLOCK-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_k      <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_borrow <= 1'b0;
      r_diff   <= '0;
      r_b_out  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a      <= in1;
            r_b      <= in2;
            r_borrow <= b_in;
            r_k      <= '0;
            r_state  <= S_RUN;
          end
        end
        S_RUN: begin
          r_diff   <= w_diff_nxt;
          r_borrow <= w_bo;
          if (r_k == c_last) begin
            r_b_out <= w_bo;
            r_k     <= '0;
            r_state <= S_DONE;
          end else begin
            r_k <= r_k + KW'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef SUB_FLAGS_EN
  logic r_zero;
  logic r_neg;
  logic r_ovf;

  // Flags are captured from the completed result on the final slice edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_zero <= 1'b0;
      r_neg  <= 1'b0;
      r_ovf  <= 1'b0;
    end else if ((r_state == S_RUN) && (r_k == c_last)) begin
      r_zero <= (w_diff_nxt == '0);
      r_neg  <= w_diff_nxt[WIDTH-1];
      r_ovf  <= (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_diff_nxt[WIDTH-1] != r_a[WIDTH-1]);
    end
  end

  assign zero = r_zero;
  assign neg  = r_neg;
  assign ovf  = r_ovf;
`endif

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign diff      = r_diff;
  assign b_out     = r_b_out;

endmodule
`default_nettype wire
